// File: rtl/writeback_unit_if.sv
// Write-back stage bus: retiring instruction, data-cache return, register file write port and stall.
interface writeback_unit_if #(
  parameter int N_Bits = 32,
  parameter int CNT_W  = 32
);
  logic              valid;
  logic              reg_write;
  logic [1:0]        result_src;
  logic [4:0]        rd;
  logic [2:0]        funct3;
  logic [N_Bits-1:0] alu_result;
  logic [N_Bits-1:0] pc_plus4;
  logic [N_Bits-1:0] mem_rdata;
  logic              mem_ready;
  logic [N_Bits-1:0] WD3;
  logic [4:0]        A3;
  logic              WE3;
  logic              stall;
  logic [CNT_W-1:0]  load_stall_cycles;

  modport master (
    output valid, reg_write, result_src, rd, funct3, alu_result, pc_plus4, mem_rdata, mem_ready,
    input  WD3, A3, WE3, stall, load_stall_cycles
  );

  modport slave (
    input  valid, reg_write, result_src, rd, funct3, alu_result, pc_plus4, mem_rdata, mem_ready,
    output WD3, A3, WE3, stall, load_stall_cycles
  );
endinterface

// File: rtl/writeback_unit.sv
// RISC-V write-back stage: result select, load extension, miss stall and registered RF write port.
module writeback_unit #(
  parameter int N_Bits = 32,
  parameter int CNT_W  = 32
) (
  input logic              clk,
  input logic              rst,
  writeback_unit_if.slave  bus
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t            r_state, w_next;
  logic [4:0]        r_rd;
  logic [2:0]        r_funct3;
  logic [1:0]        r_off;
  logic              r_we;
  logic [N_Bits-1:0] r_WD3;
  logic [4:0]        r_A3;
  logic              r_WE3;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_stall, w_capture, w_wr_en;
  logic [N_Bits-1:0] w_wr_data;
  logic [4:0]        w_wr_addr;

  // Byte/halfword lanes are picked from the aligned word by the address offset.
  function automatic logic [N_Bits-1:0] f_ext(input logic [N_Bits-1:0] d,
                                              input logic [2:0] f3,
                                              input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{off, 3'b000} +: 8];
    h = d[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  f_ext = {{(N_Bits-8){b[7]}}, b};
      3'b001:  f_ext = {{(N_Bits-16){h[15]}}, h};
      3'b100:  f_ext = {{(N_Bits-8){1'b0}}, b};
      3'b101:  f_ext = {{(N_Bits-16){1'b0}}, h};
      default: f_ext = d;
    endcase
  endfunction

  always_comb begin
    w_next    = r_state;
    w_stall   = 1'b0;
    w_capture = 1'b0;
    w_wr_en   = 1'b0;
    w_wr_data = bus.alu_result;
    w_wr_addr = bus.rd;
    case (r_state)
      IDLE: begin
        if (bus.valid) begin
          if (bus.result_src == 2'b01) begin
            if (bus.mem_ready) begin
              w_wr_en   = bus.reg_write && (bus.rd != 5'd0);
              w_wr_data = f_ext(bus.mem_rdata, bus.funct3, bus.alu_result[1:0]);
            end else begin
              w_capture = 1'b1;
              w_stall   = 1'b1;
              w_next    = WAIT_MEM;
            end
          end else begin
            w_wr_en   = bus.reg_write && (bus.rd != 5'd0);
            w_wr_data = (bus.result_src == 2'b10) ? bus.pc_plus4 : bus.alu_result;
          end
        end
      end
      WAIT_MEM: begin
        w_stall   = !bus.mem_ready;
        w_wr_addr = r_rd;
        w_wr_data = f_ext(bus.mem_rdata, r_funct3, r_off);
        if (bus.mem_ready) begin
          w_wr_en = r_we && (r_rd != 5'd0);
          w_next  = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rd     <= '0;
      r_funct3 <= '0;
      r_off    <= '0;
      r_we     <= 1'b0;
      r_WD3    <= '0;
      r_A3     <= '0;
      r_WE3    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      r_WE3   <= w_wr_en;
      if (w_wr_en) begin
        r_WD3 <= w_wr_data;
        r_A3  <= w_wr_addr;
      end
      if (w_capture) begin
        r_rd     <= bus.rd;
        r_funct3 <= bus.funct3;
        r_off    <= bus.alu_result[1:0];
        r_we     <= bus.reg_write;
      end
      if (w_stall && (r_cnt != '1))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.stall             = w_stall && !rst;
  assign bus.WD3               = r_WD3;
  assign bus.A3                = r_A3;
  assign bus.WE3               = r_WE3;
  assign bus.load_stall_cycles = r_cnt;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: result select, load extension, miss stall, reset and counter saturation.
module tb_writeback_unit;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  writeback_unit_if #(.N_Bits(32), .CNT_W(32)) bus ();
  writeback_unit_if #(.N_Bits(32), .CNT_W(4))  bus4 ();

  writeback_unit #(.N_Bits(32), .CNT_W(32)) dut  (.clk(clk), .rst(rst), .bus(bus));
  writeback_unit #(.N_Bits(32), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.valid = 0; bus.reg_write = 0; bus.result_src = 0; bus.rd = 0; bus.funct3 = 0;
    bus.alu_result = 0; bus.pc_plus4 = 0; bus.mem_rdata = 0; bus.mem_ready = 0;
    bus4.valid = 0; bus4.reg_write = 0; bus4.result_src = 0; bus4.rd = 0; bus4.funct3 = 0;
    bus4.alu_result = 0; bus4.pc_plus4 = 0; bus4.mem_rdata = 0; bus4.mem_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    tick(); tick();
    tests++; if (bus.WE3 !== 1'b0) begin fails++; $display("FAIL reset_we3 got %b exp 0", bus.WE3); end
    tests++; if (bus.A3 !== 5'd0) begin fails++; $display("FAIL reset_a3 got %0d exp 0", bus.A3); end
    tests++; if (bus.WD3 !== 32'h0) begin fails++; $display("FAIL reset_wd3 got %h exp 0", bus.WD3); end
    tests++; if (bus.load_stall_cycles !== 32'd0) begin fails++; $display("FAIL reset_cnt got %0d exp 0", bus.load_stall_cycles); end
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b exp 0", bus.stall); end
    rst = 0;
    tick();
  endtask

  task automatic test_alu();
    bus.valid = 1; bus.reg_write = 1; bus.result_src = 2'b00; bus.rd = 5;
    bus.alu_result = 32'h1234_5678; bus.pc_plus4 = 32'hAAAA_0000;
    #1;
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL alu_stall got %b exp 0", bus.stall); end
    tick();
    bus.valid = 0;
    tests++; if (bus.WE3 !== 1'b1 || bus.A3 !== 5'd5 || bus.WD3 !== 32'h1234_5678) begin
      fails++; $display("FAIL alu_write got we=%b a=%0d d=%h exp we=1 a=5 d=12345678", bus.WE3, bus.A3, bus.WD3); end
    tick();
    tests++; if (bus.WE3 !== 1'b0 || bus.WD3 !== 32'h1234_5678) begin
      fails++; $display("FAIL alu_after got we=%b d=%h exp we=0 d=12345678", bus.WE3, bus.WD3); end
    // reserved result_src behaves as ALU
    bus.valid = 1; bus.result_src = 2'b11; bus.rd = 6; bus.alu_result = 32'h0BAD_F00D;
    tick();
    bus.valid = 0;
    tests++; if (bus.WE3 !== 1'b1 || bus.A3 !== 5'd6 || bus.WD3 !== 32'h0BAD_F00D) begin
      fails++; $display("FAIL src11_write got we=%b a=%0d d=%h exp we=1 a=6 d=0badf00d", bus.WE3, bus.A3, bus.WD3); end
    tick();
  endtask

  task automatic test_jal();
    bus.valid = 1; bus.reg_write = 1; bus.result_src = 2'b10; bus.rd = 1;
    bus.pc_plus4 = 32'h0000_0104; bus.alu_result = 32'h0000_0F00;
    tick();
    tests++; if (bus.WE3 !== 1'b1 || bus.A3 !== 5'd1 || bus.WD3 !== 32'h0000_0104) begin
      fails++; $display("FAIL jal_write got we=%b a=%0d d=%h exp we=1 a=1 d=104", bus.WE3, bus.A3, bus.WD3); end
    bus.rd = 0; bus.pc_plus4 = 32'h0000_0200;
    tick();
    bus.valid = 0;
    tests++; if (bus.WE3 !== 1'b0 || bus.A3 !== 5'd1 || bus.WD3 !== 32'h0000_0104) begin
      fails++; $display("FAIL jal_x0 got we=%b a=%0d d=%h exp we=0 a=1 d=104", bus.WE3, bus.A3, bus.WD3); end
    bus.valid = 1; bus.rd = 3; bus.reg_write = 0;
    tick();
    bus.valid = 0;
    tests++; if (bus.WE3 !== 1'b0) begin fails++; $display("FAIL no_regwrite got we=%b exp 0", bus.WE3); end
    bus.mem_ready = 1;
    tick();
    bus.mem_ready = 0;
    tests++; if (bus.WE3 !== 1'b0 || bus.stall !== 1'b0) begin
      fails++; $display("FAIL idle_ready got we=%b stall=%b exp 0 0", bus.WE3, bus.stall); end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3 [6];
    logic [1:0]  off[6];
    logic [31:0] exp[6];
    f3[0] = 3'b000; off[0] = 2'd0; exp[0] = 32'hFFFF_FF81;
    f3[1] = 3'b100; off[1] = 2'd3; exp[1] = 32'h0000_0080;
    f3[2] = 3'b001; off[2] = 2'd2; exp[2] = 32'hFFFF_80FF;
    f3[3] = 3'b101; off[3] = 2'd0; exp[3] = 32'h0000_7F81;
    f3[4] = 3'b010; off[4] = 2'd0; exp[4] = 32'h80FF_7F81;
    f3[5] = 3'b011; off[5] = 2'd1; exp[5] = 32'h80FF_7F81;
    bus.mem_rdata = 32'h80FF_7F81; bus.mem_ready = 1; bus.reg_write = 1; bus.result_src = 2'b01;
    for (int i = 0; i < 6; i++) begin
      bus.valid = 1; bus.funct3 = f3[i]; bus.rd = 5'(10 + i); bus.alu_result = 32'h0000_1000 | 32'(off[i]);
      #1;
      tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL ld_stall%0d got %b exp 0", i, bus.stall); end
      tick();
      tests++; if (bus.WE3 !== 1'b1 || bus.A3 !== 5'(10 + i) || bus.WD3 !== exp[i]) begin
        fails++; $display("FAIL ld_ext%0d got we=%b a=%0d d=%h exp we=1 a=%0d d=%h", i, bus.WE3, bus.A3, bus.WD3, 10 + i, exp[i]); end
    end
    bus.valid = 0; bus.mem_ready = 0;
    tick();
  endtask

  task automatic test_miss();
    int nstall;
    nstall = 0;
    bus.valid = 1; bus.reg_write = 1; bus.result_src = 2'b01; bus.funct3 = 3'b010; bus.rd = 7;
    bus.alu_result = 32'h0000_2000; bus.mem_ready = 0; bus.mem_rdata = 32'h1111_1111;
    #1;
    if (bus.stall === 1'b1) nstall++;
    tick();
    for (int c = 0; c < 2; c++) begin
      // upstream inputs change during the wait and must be ignored
      bus.rd = 5'(20 + c); bus.result_src = 2'b00; bus.funct3 = 3'b000; bus.alu_result = 32'h0000_0055;
      #1;
      if (bus.stall === 1'b1) nstall++;
      tests++; if (bus.WE3 !== 1'b0) begin fails++; $display("FAIL miss_wait_we%0d got %b exp 0", c, bus.WE3); end
      tick();
    end
    bus.mem_ready = 1; bus.mem_rdata = 32'hDEAD_BEEF;
    #1;
    if (bus.stall === 1'b1) nstall++;
    tests++; if (nstall !== 3) begin fails++; $display("FAIL miss_stall_cycles got %0d exp 3", nstall); end
    tick();
    bus.valid = 0; bus.mem_ready = 0;
    tests++; if (bus.WE3 !== 1'b1 || bus.A3 !== 5'd7 || bus.WD3 !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL miss_write got we=%b a=%0d d=%h exp we=1 a=7 d=deadbeef", bus.WE3, bus.A3, bus.WD3); end
    tests++; if (bus.load_stall_cycles !== 32'd3) begin fails++; $display("FAIL miss_cnt got %0d exp 3", bus.load_stall_cycles); end
    tick();
    tests++; if (bus.WE3 !== 1'b0 || bus.stall !== 1'b0) begin
      fails++; $display("FAIL miss_after got we=%b stall=%b exp 0 0", bus.WE3, bus.stall); end
  endtask

  task automatic test_reset_wait();
    bus.valid = 1; bus.reg_write = 1; bus.result_src = 2'b01; bus.funct3 = 3'b010; bus.rd = 9;
    bus.mem_ready = 0;
    tick();
    bus.valid = 0; rst = 1; bus.mem_ready = 1; bus.mem_rdata = 32'h5555_AAAA;
    #1;
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL rstw_stall got %b exp 0", bus.stall); end
    tick();
    rst = 0;
    tests++; if (bus.WE3 !== 1'b0 || bus.load_stall_cycles !== 32'd0) begin
      fails++; $display("FAIL rstw_state got we=%b cnt=%0d exp 0 0", bus.WE3, bus.load_stall_cycles); end
    tick();
    bus.mem_ready = 0;
    #1;
    tests++; if (bus.WE3 !== 1'b0 || bus.stall !== 1'b0) begin
      fails++; $display("FAIL rstw_idle got we=%b stall=%b exp 0 0", bus.WE3, bus.stall); end
  endtask

  task automatic test_saturation();
    bus4.valid = 1; bus4.reg_write = 1; bus4.result_src = 2'b01; bus4.funct3 = 3'b010; bus4.rd = 4;
    bus4.mem_ready = 0;
    tick();
    bus4.valid = 0;
    for (int c = 1; c < 20; c++) tick();
    tests++; if (bus4.load_stall_cycles !== 4'd15 || bus4.stall !== 1'b1) begin
      fails++; $display("FAIL sat_cnt got cnt=%0d stall=%b exp 15 1", bus4.load_stall_cycles, bus4.stall); end
    bus4.mem_ready = 1; bus4.mem_rdata = 32'h0000_00C3;
    tick();
    bus4.mem_ready = 0;
    tests++; if (bus4.load_stall_cycles !== 4'd15 || bus4.WE3 !== 1'b1 || bus4.WD3 !== 32'h0000_00C3) begin
      fails++; $display("FAIL sat_end got cnt=%0d we=%b d=%h exp 15 1 c3", bus4.load_stall_cycles, bus4.WE3, bus4.WD3); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1;
    idle_inputs();
    test_reset();
    test_alu();
    test_jal();
    test_load_ext();
    test_miss();
    test_reset_wait();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/writeback_unit.md
# writeback_unit

Final write-back stage of the RISC-V core. It selects the result of each retiring instruction (ALU result, load data or PC+4) and drives the register file write port (WD3/A3/WE3) one cycle later. Loads that miss in the data cache are held: the unit asserts a stall until the cache returns data. Load data is sign- or zero-extended per funct3 before it is written.

## Interface
- N_Bits, 32, datapath and register width
- CNT_W, 32, width of the load-stall performance counter
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- valid  in  1  an instruction is retiring this cycle
- reg_write  in  1  the instruction writes rd
- result_src  in  2  00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU)
- rd  in  5  destination register
- funct3  in  3  load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
- alu_result  in  N_Bits  ALU result; for loads it is the address (bits [1:0] are the byte offset)
- pc_plus4  in  N_Bits  PC+4 of the instruction
- mem_rdata  in  N_Bits  aligned word from the data cache
- mem_ready  in  1  mem_rdata is valid this cycle
- WD3  out  N_Bits  register file write data (registered)
- A3  out  5  register file write address (registered)
- WE3  out  1  register file write enable (registered)
- stall  out  1  combinational; hold upstream stages and keep inputs stable
- load_stall_cycles  out  CNT_W  saturating count of cycles with stall=1

## Operation
- FSM states: IDLE and WAIT_MEM.
- **IDLE, accepting an instruction.** An instruction is accepted when valid=1.
  - With reg_write=1 and rd≠0, the unit registers WD3, A3 and WE3=1.
  - Write data is alu_result for result_src=00/11, and pc_plus4 for result_src=10.
- **IDLE, load with data ready.** For a load (result_src=01) with mem_ready=1 in the same cycle, the extended data is written next cycle. No stall is raised.
- **IDLE, load without data.** For a load with mem_ready=0:
  - Capture rd, funct3, alu_result[1:0] and reg_write.
  - Go to WAIT_MEM. stall=1 in this cycle.
- **WAIT_MEM.**
  - stall = !mem_ready.
  - All instruction inputs are ignored.
  - When mem_ready=1, the captured fields and extended mem_rdata produce the write next cycle, and the FSM returns to IDLE.
- **Load extension.**
  - Byte lane = mem_rdata[8*off +: 8].
  - Halfword = mem_rdata[16*off[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW uses the full word and ignores off.
  - funct3 values 011, 110 and 111 are treated as LW.
- **Suppressed writes.** rd=0 or reg_write=0 never asserts WE3. A load to x0 still waits for mem_ready and still stalls.
- **Default outputs.** WE3=0 in any cycle with no accepted write. WD3 and A3 hold their last values.
- **Stall counter.** load_stall_cycles increments every cycle with stall=1. It saturates at all-ones and does not wrap.

## Timing
- **Reset values.** When rst=1 the unit goes to IDLE and sets WD3=0, A3=0, WE3=0, load_stall_cycles=0. stall=0 during reset.
- **Reset during WAIT_MEM.** The pending load is dropped with no write. A mem_ready arriving in the reset cycle is ignored.
- **Latency, non-load and ready load.** The write appears at the register file on the edge after acceptance: WE3 is high in cycle N+1 and the register file commits at the end of N+1.
- **Latency, missed load.** If mem_ready arrives k cycles after acceptance, WE3 is high in cycle N+k+1. stall is high in cycles N through N+k−1, for k cycles in total.
- **Back-to-back instructions.** Writes in consecutive cycles are supported with no bubble. In WAIT_MEM, valid from upstream is ignored because upstream is stalled and holding its inputs.
- **mem_ready outside a load.** mem_ready=1 in IDLE with no load accepted is ignored.

## Test plan
- ALU write: valid=1, result_src=00, rd=5, alu_result=0x1234_5678 → next cycle WE3=1, A3=5, WD3=0x1234_5678; the following cycle WE3=0.
- JAL link: result_src=10, rd=1, pc_plus4=0x0000_0104 → WD3=0x104, A3=1 one cycle later. The same instruction with rd=0 → WE3 stays 0.
- Load extension with mem_ready=1 and mem_rdata=0x80FF_7F81:
  - LB with off=0 → 0xFFFF_FF81.
  - LBU with off=3 → 0x0000_0080.
  - LH with off=2 → 0xFFFF_80FF.
  - LHU with off=0 → 0x0000_7F81.
  - LW → 0x80FF_7F81.
- Miss: LW to rd=7 with mem_ready low for 3 cycles, then high with data 0xDEAD_BEEF:
  - stall is high for exactly 3 cycles and instruction inputs change during the wait without effect.
  - WE3=1, A3=7, WD3=0xDEAD_BEEF one cycle after mem_ready.
  - load_stall_cycles=3.
- Reset in WAIT_MEM: assert rst one cycle into a miss, then raise mem_ready → no WE3 pulse, stall=0, counter=0, FSM in IDLE.
- Counter saturation: with CNT_W=4, hold a miss for 20 cycles → load_stall_cycles stays at 15.
